// File: rtl/aes_round_ctrl_if.sv
// Handshake bundle between the AES round sequencer and its peers:
// top-level start/done, key expander, and the round datapath.
interface aes_round_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic       data_load;
  logic       kx_enable;
  logic       kx_ack;
  logic       kx_ready;
  logic [3:0] kx_transform;
  logic       rnd_start;
  logic [1:0] rnd_type;
  logic       rnd_done;
  logic [3:0] round_idx;

  modport master (
    output start, kx_ready, kx_transform, rnd_done,
    input  busy, done, err, data_load, kx_enable, kx_ack, rnd_start, rnd_type, round_idx
  );

  modport slave (
    input  start, kx_ready, kx_transform, rnd_done,
    output busy, done, err, data_load, kx_enable, kx_ack, rnd_start, rnd_type, round_idx
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 block sequencer: pairs each round key from the expander with one datapath round.
// Optional wait-timeout abort enabled by defining AES_CTRL_TIMEOUT_EN.
module aes_round_ctrl #(
  parameter int NR             = 10,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input logic             clk,
  input logic             reset_n,
  aes_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, KWAIT, RSTART, RWAIT, KACK, DONE
`ifdef AES_CTRL_TIMEOUT_EN
    , ERR
`endif
  } state_t;

  localparam logic [3:0] LAST     = 4'(NR);
  localparam logic [1:0] RT_ADD   = 2'd0;
  localparam logic [1:0] RT_FULL  = 2'd1;
  localparam logic [1:0] RT_FINAL = 2'd2;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TW) || NR < 1 || NR > 15) begin : g_cfg_check
    $error("aes_round_ctrl: NR/TIMEOUT_CYCLES/TW out of range");
  end

  state_t     state;
  logic       busy_q, done_q, data_load_q, kx_enable_q, kx_ack_q, rnd_start_q;
  logic [1:0] rnd_type_q;
  logic [3:0] round_idx_q;
  logic       key_hit;

  // Only the key tagged with the current round counts; stale ready is waited out.
  assign key_hit = bus.kx_ready && (bus.kx_transform == round_idx_q);

`ifdef AES_CTRL_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES - 1);
  logic          err_q;
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_load_q <= 1'b0;
      kx_enable_q <= 1'b0;
      kx_ack_q    <= 1'b0;
      rnd_start_q <= 1'b0;
      rnd_type_q  <= RT_ADD;
      round_idx_q <= '0;
`ifdef AES_CTRL_TIMEOUT_EN
      err_q       <= 1'b0;
      tcnt        <= '0;
`endif
    end else begin
      data_load_q <= 1'b0;
      kx_ack_q    <= 1'b0;
      rnd_start_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state)
        IDLE: if (bus.start) begin
          state       <= LOAD;
          busy_q      <= 1'b1;
          data_load_q <= 1'b1;
          kx_enable_q <= 1'b1;
          round_idx_q <= '0;
        end
        LOAD: begin
          state <= KWAIT;
`ifdef AES_CTRL_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        KWAIT: begin
          if (key_hit) begin
            state       <= RSTART;
            rnd_start_q <= 1'b1;
            rnd_type_q  <= (round_idx_q == '0)  ? RT_ADD :
                           (round_idx_q == LAST) ? RT_FINAL : RT_FULL;
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (tcnt == TO_LIM) begin
            state       <= ERR;
            err_q       <= 1'b1;
            kx_enable_q <= 1'b0;
          end else tcnt <= tcnt + 1'b1;
`endif
        end
        RSTART: begin
          state <= RWAIT;
`ifdef AES_CTRL_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        RWAIT: begin
          if (bus.rnd_done) begin
            state    <= KACK;
            kx_ack_q <= 1'b1;
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (tcnt == TO_LIM) begin
            state       <= ERR;
            err_q       <= 1'b1;
            kx_enable_q <= 1'b0;
          end else tcnt <= tcnt + 1'b1;
`endif
        end
        KACK: begin
          if (round_idx_q == LAST) begin
            state       <= DONE;
            done_q      <= 1'b1;
            kx_enable_q <= 1'b0;
          end else begin
            state       <= KWAIT;
            round_idx_q <= round_idx_q + 4'd1;
`ifdef AES_CTRL_TIMEOUT_EN
            tcnt        <= '0;
`endif
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
`ifdef AES_CTRL_TIMEOUT_EN
        ERR: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.data_load = data_load_q;
  assign bus.kx_enable = kx_enable_q;
  assign bus.kx_ack    = kx_ack_q;
  assign bus.rnd_start = rnd_start_q;
  assign bus.rnd_type  = rnd_type_q;
  assign bus.round_idx = round_idx_q;
`ifdef AES_CTRL_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with small expander/datapath peer models.
module tb_aes_round_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  aes_round_ctrl_if bus();

  aes_round_ctrl #(.NR(10), .TIMEOUT_CYCLES(16), .TW(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc, rs_cnt, ack_cnt, done_cnt, load_cnt, err_cnt, err_t;
  logic [1:0] rtype_log [16];
  logic [3:0] ridx_log [16];
  int rs_t [16];
  int ack_t [16];
  // peer model knobs/state
  int kx_lat, slow_key, slow_lat, exp_idx, kdly;
  bit dp_en, dp_spur, dp_pend;

  task automatic clear_stats();
    cyc = 0; rs_cnt = 0; ack_cnt = 0; done_cnt = 0; load_cnt = 0; err_cnt = 0; err_t = -1;
    exp_idx = 0; kdly = 0; dp_pend = 0;
  endtask

  // One clock: observe outputs at negedge, then drive peer responses for the next edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.data_load) begin load_cnt++; exp_idx = 0; kdly = 0; end
    if (bus.rnd_start) begin
      if (rs_cnt < 16) begin
        rtype_log[rs_cnt] = bus.rnd_type; ridx_log[rs_cnt] = bus.round_idx; rs_t[rs_cnt] = cyc;
      end
      rs_cnt++;
      if (dp_en) dp_pend = 1;
    end
    if (bus.kx_ack) begin
      if (ack_cnt < 16) ack_t[ack_cnt] = cyc;
      ack_cnt++;
      exp_idx++;
      kdly = (exp_idx == slow_key) ? slow_lat : kx_lat;
    end else if (kdly > 0) kdly--;
    if (bus.done) done_cnt++;
    if (bus.err) begin err_cnt++; err_t = cyc; end
    bus.kx_ready     = 1'b1;
    bus.kx_transform = 4'((kdly == 0) ? exp_idx : exp_idx - 1);
    if (dp_spur) bus.rnd_done = 1'b1;
    else if (dp_pend && !bus.rnd_start) begin bus.rnd_done = 1'b1; dp_pend = 0; end
    else bus.rnd_done = 1'b0;
  endtask

  task automatic run_block(input int budget, output int lat);
    clear_stats();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (done_cnt == 0 && cyc < budget) step();
    lat = cyc;
    step();
  endtask

  task automatic test_reset();
    bus.start = 0; bus.kx_ready = 0; bus.kx_transform = 0; bus.rnd_done = 0;
    kx_lat = 0; slow_key = -1; slow_lat = 0; dp_en = 1; dp_spur = 0;
    clear_stats();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end checks++;
    if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end checks++;
    if (bus.err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end checks++;
    if (bus.data_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", bus.data_load); end checks++;
    if (bus.kx_enable !== 1'b0) begin errors++; $display("FAIL reset_kxen: got %b want 0", bus.kx_enable); end checks++;
    if (bus.kx_ack !== 1'b0)    begin errors++; $display("FAIL reset_kxack: got %b want 0", bus.kx_ack); end checks++;
    if (bus.rnd_start !== 1'b0) begin errors++; $display("FAIL reset_rstart: got %b want 0", bus.rnd_start); end checks++;
    if (bus.rnd_type !== 2'd0)  begin errors++; $display("FAIL reset_rtype: got %0d want 0", bus.rnd_type); end checks++;
    if (bus.round_idx !== 4'd0) begin errors++; $display("FAIL reset_ridx: got %0d want 0", bus.round_idx); end checks++;
    reset_n = 1'b1;
    repeat (3) step();
    if (bus.busy !== 1'b0 || load_cnt != 0) begin errors++; $display("FAIL idle_no_start: busy %b loads %0d want 0/0", bus.busy, load_cnt); end checks++;
  endtask

  task automatic test_full_block();
    int lat;
    kx_lat = 2;
    run_block(200, lat);
    if (lat != 56)      begin errors++; $display("FAIL blk_latency: got %0d want 56", lat); end checks++;
    if (rs_cnt != 11)   begin errors++; $display("FAIL blk_rstart_cnt: got %0d want 11", rs_cnt); end checks++;
    if (ack_cnt != 11)  begin errors++; $display("FAIL blk_ack_cnt: got %0d want 11", ack_cnt); end checks++;
    if (done_cnt != 1)  begin errors++; $display("FAIL blk_done_cnt: got %0d want 1", done_cnt); end checks++;
    for (int i = 0; i < 11; i++) begin
      logic [1:0] et;
      et = (i == 0) ? 2'd0 : (i == 10) ? 2'd2 : 2'd1;
      if (rtype_log[i] !== et) begin errors++; $display("FAIL blk_rtype[%0d]: got %0d want %0d", i, rtype_log[i], et); end checks++;
      if (ridx_log[i] !== 4'(i)) begin errors++; $display("FAIL blk_ridx[%0d]: got %0d want %0d", i, ridx_log[i], i); end checks++;
    end
    if (bus.busy !== 1'b0 || bus.kx_enable !== 1'b0) begin errors++; $display("FAIL blk_end_idle: busy %b kxen %b want 0/0", bus.busy, bus.kx_enable); end checks++;
  endtask

  task automatic test_zero_wait_latency();
    int lat;
    kx_lat = 0;
    run_block(200, lat);
    if (lat != 46)     begin errors++; $display("FAIL zw_latency: got %0d want 46", lat); end checks++;
    if (ack_cnt != 11) begin errors++; $display("FAIL zw_ack_cnt: got %0d want 11", ack_cnt); end checks++;
  endtask

  task automatic test_back_to_back();
    logic pbusy;
    int rs_at, ack_at;
    kx_lat = 0;
    clear_stats();
    rs_at = 0; ack_at = 0;
    bus.start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      pbusy = bus.busy;
      step();
      if (bus.data_load) begin
        if (pbusy !== 1'b0) begin errors++; $display("FAIL b2b_load_from_idle: prev busy %b want 0 at cyc %0d", pbusy, cyc); end checks++;
        if (load_cnt > 1) begin
          if (rs_cnt - rs_at != 11 || ack_cnt - ack_at != 11) begin
            errors++; $display("FAIL b2b_rounds: rstart %0d ack %0d want 11/11", rs_cnt - rs_at, ack_cnt - ack_at);
          end
          checks++;
        end
        rs_at = rs_cnt; ack_at = ack_cnt;
      end
    end
    bus.start = 1'b0;
    if (load_cnt != 3 || done_cnt != 2) begin errors++; $display("FAIL b2b_counts: loads %0d dones %0d want 3/2", load_cnt, done_cnt); end checks++;
    for (int c = 0; c < 100 && bus.busy; c++) step();
    if (done_cnt != 3 || rs_cnt != 33 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: dones %0d rstart %0d busy %b want 3/33/0", done_cnt, rs_cnt, bus.busy);
    end
    checks++;
  endtask

  task automatic test_stale_key();
    int lat;
    kx_lat = 0; slow_key = 4; slow_lat = 6;
    run_block(200, lat);
    slow_key = -1;
    if (rs_t[4] - ack_t[3] != 7) begin errors++; $display("FAIL stale_gap: got %0d want 7", rs_t[4] - ack_t[3]); end checks++;
    if (ridx_log[4] !== 4'd4)    begin errors++; $display("FAIL stale_ridx: got %0d want 4", ridx_log[4]); end checks++;
    if (rs_t[5] - ack_t[4] != 2) begin errors++; $display("FAIL stale_next_gap: got %0d want 2", rs_t[5] - ack_t[4]); end checks++;
    if (rs_cnt != 11 || lat != 51) begin errors++; $display("FAIL stale_total: rstart %0d lat %0d want 11/51", rs_cnt, lat); end checks++;
  endtask

  task automatic test_reset_midop();
    int lat;
    kx_lat = 0;
    clear_stats();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (rs_cnt < 6 && cyc < 100) step();
    dp_en = 0; dp_pend = 0;
    step();
    if (bus.round_idx !== 4'd5 || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_pre: ridx %0d busy %b want 5/1", bus.round_idx, bus.busy); end checks++;
    #2 reset_n = 1'b0;
    #1;
    if (bus.busy !== 1'b0 || bus.kx_enable !== 1'b0) begin errors++; $display("FAIL mid_async_ctl: busy %b kxen %b want 0/0", bus.busy, bus.kx_enable); end checks++;
    if (bus.round_idx !== 4'd0 || bus.rnd_type !== 2'd0) begin errors++; $display("FAIL mid_async_idx: ridx %0d rtype %0d want 0/0", bus.round_idx, bus.rnd_type); end checks++;
    @(negedge clk);
    reset_n = 1'b1;
    dp_en = 1;
    run_block(200, lat);
    if (lat != 46 || rs_cnt != 11) begin errors++; $display("FAIL mid_rerun: lat %0d rstart %0d want 46/11", lat, rs_cnt); end checks++;
    if (ridx_log[0] !== 4'd0 || ridx_log[10] !== 4'd10) begin errors++; $display("FAIL mid_rerun_idx: first %0d last %0d want 0/10", ridx_log[0], ridx_log[10]); end checks++;
  endtask

  task automatic test_spurious_done();
    int lat;
    kx_lat = 2; dp_spur = 1;
    run_block(200, lat);
    dp_spur = 0;
    if (lat != 56)     begin errors++; $display("FAIL spur_latency: got %0d want 56", lat); end checks++;
    if (ack_cnt != 11 || rs_cnt != 11) begin errors++; $display("FAIL spur_counts: ack %0d rstart %0d want 11/11", ack_cnt, rs_cnt); end checks++;
    for (int i = 0; i < 10; i++) begin
      if (!(ack_t[i] > rs_t[i] && ack_t[i] < rs_t[i+1])) begin
        errors++; $display("FAIL spur_order[%0d]: ack at %0d rstart %0d..%0d", i, ack_t[i], rs_t[i], rs_t[i+1]);
      end
      checks++;
    end
  endtask

  task automatic test_timeout();
    kx_lat = 0; dp_en = 0;
    clear_stats();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
    while (err_cnt == 0 && cyc < 60) step();
    if (err_t != rs_t[0] + 17) begin errors++; $display("FAIL to_err_time: got %0d want %0d", err_t, rs_t[0] + 17); end checks++;
    if (bus.kx_enable !== 1'b0 || ack_cnt != 0) begin errors++; $display("FAIL to_err_state: kxen %b acks %0d want 0/0", bus.kx_enable, ack_cnt); end checks++;
    step();
    if (bus.busy !== 1'b0 || bus.err !== 1'b0 || err_cnt != 1) begin errors++; $display("FAIL to_idle: busy %b err %b errs %0d want 0/0/1", bus.busy, bus.err, err_cnt); end checks++;
`else
    repeat (40) step();
    if (err_cnt != 0 || bus.busy !== 1'b1) begin errors++; $display("FAIL to_off_wait: errs %0d busy %b want 0/1", err_cnt, bus.busy); end checks++;
    if (ack_cnt != 0 || rs_cnt != 1) begin errors++; $display("FAIL to_off_stuck: acks %0d rstart %0d want 0/1", ack_cnt, rs_cnt); end checks++;
`endif
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    dp_en = 1;
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_zero_wait_latency();
    test_back_to_back();
    test_stale_key();
    test_reset_midop();
    test_spurious_done();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
